// File: rtl/sc_fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package sc_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Beat counter must hold BURST_MAX itself without wrapping.
    function automatic int cnt_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDW = $clog2(N);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            automatic int k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                gnt[k] = 1'b1;
                idx    = IDW'(k);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; a burst is admitted only
// when the FIFO can absorb a full BURST_MAX burst, so an admitted burst never stalls.
module sc_fifo_wr_arbiter
    import sc_fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    input  logic [N_REQ-1:0]           req_last_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       fifo_wr_en_o,
    output logic [DATA_W-1:0]          fifo_wr_data_o,
    input  logic [ADDR_W:0]            fifo_wr_usedw_i,
    input  logic                       fifo_wr_full_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       busy_o
);

    localparam int                IDW      = $clog2(N_REQ);
    localparam int                CNT_W    = cnt_width(BURST_MAX);
    localparam logic [ADDR_W+1:0] DEPTH    = (ADDR_W+2)'(2**ADDR_W);
    localparam logic [ADDR_W+1:0] NEED     = (ADDR_W+2)'(BURST_MAX);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_MAX - 1);
    localparam logic [IDW-1:0]    TOP_ID   = IDW'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDW-1:0]    pick_idx;
    logic              pick_any;
    logic [ADDR_W+1:0] free;
    logic              owner_valid;
    logic              owner_last;
    logic              accept;

    assign free        = DEPTH - {1'b0, fifo_wr_usedw_i};
    assign owner_valid = req_valid_i[id_q];
    assign owner_last  = req_last_i[id_q];

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Gating with rst_i keeps a mid-burst reset cycle from issuing a write.
    always_comb begin
        req_ready_o    = '0;
        fifo_wr_data_o = '0;
        if (state_q == GRANT && !rst_i) begin
            fifo_wr_data_o = req_data_i[id_q*DATA_W +: DATA_W];
            if (!fifo_wr_full_i)
                req_ready_o = grant_q;
        end
    end

    assign accept       = owner_valid & req_ready_o[id_q];
    assign fifo_wr_en_o = accept;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any && free >= NEED) begin
                    state_d = GRANT;
                    grant_d = pick_gnt;
                    id_d    = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept)
                    cnt_d = cnt_q + 1'b1;
                // An owner with valid low has nothing further; full alone holds the grant.
                if (!owner_valid || (accept && (owner_last || cnt_q == LAST_CNT))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (id_q == TOP_ID) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = id_q;
    assign busy_o     = (state_q == GRANT);

endmodule

// File: tb/tb_sc_fifo_wr_arbiter.sv
// Scoreboard bench: requester queues and a FIFO occupancy model drive the arbiter;
// a monitor pops expected (owner, word) pairs on every FIFO write.
module tb_sc_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_valid_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]  req_last_i;
    logic [N-1:0]  req_ready_o;
    logic          fifo_wr_en_o;
    logic [DW-1:0] fifo_wr_data_o;
    logic [AW:0]   fifo_wr_usedw_i;
    logic          fifo_wr_full_i;
    logic [N-1:0]  grant_o;
    logic [1:0]    grant_id_o;
    logic          busy_o;

    sc_fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .BURST_MAX(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .fifo_wr_data_o  (fifo_wr_data_o),
        .fifo_wr_usedw_i (fifo_wr_usedw_i),
        .fifo_wr_full_i  (fifo_wr_full_i),
        .grant_o         (grant_o),
        .grant_id_o      (grant_id_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    word_t rq[N][$];
    exp_t  exp_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    tnum  = 0;
    int    usedw = 0;
    int    drain_req = 0;
    int    drain_done = 0;
    int    preset_seq = 0;
    int    preset_seen = 0;
    int    preset_val = 0;

    assign fifo_wr_usedw_i = (AW+1)'(usedw);
    assign fifo_wr_full_i  = (usedw == 2**AW);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int r, input int i);
        return {8'(tnum), 8'(r), 16'(i)};
    endfunction

    task automatic push_req(input int r, input int first, input int n, input bit last_at_end);
        word_t w;
        for (int i = first; i < first + n; i++) begin
            w.data = word_of(r, i);
            w.last = last_at_end && (i == first + n - 1);
            rq[r].push_back(w);
        end
    endtask

    task automatic exp_req(input int r, input int first, input int n);
        exp_t e;
        for (int i = first; i < first + n; i++) begin
            e.id   = 2'(r);
            e.data = word_of(r, i);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        @(negedge clk_i);
        while ((exp_q.size() != 0 || busy_o) && n < max) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_timeout", 32'(n >= max), 32'd0);
        cyc(1);
    endtask

    task automatic preset(input int v);
        preset_val = v;
        preset_seq++;
    endtask

    task automatic flush_reqs();
        for (int k = 0; k < N; k++) rq[k].delete();
    endtask

    // Requesters and FIFO occupancy: handshake sampled mid-cycle, state advanced after the edge.
    initial begin
        logic [N-1:0] hs;
        logic         wr;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        forever begin
            @(negedge clk_i);
            hs = req_valid_i & req_ready_o;
            wr = fifo_wr_en_o;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++)
                if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            if (preset_seen != preset_seq) begin
                usedw       = preset_val;
                preset_seen = preset_seq;
            end else begin
                usedw = usedw + int'(wr);
                if (drain_done < drain_req && usedw > 0) begin
                    usedw--;
                    drain_done++;
                end
            end
            #2;
            for (int k = 0; k < N; k++) begin
                if (rq[k].size() > 0) begin
                    req_valid_i[k]           = 1'b1;
                    req_data_i[k*DW +: DW]   = rq[k][0].data;
                    req_last_i[k]            = rq[k][0].last;
                end else begin
                    req_valid_i[k]           = 1'b0;
                    req_data_i[k*DW +: DW]   = '0;
                    req_last_i[k]            = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (fifo_wr_en_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr", 32'(fifo_wr_en_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_id", 32'(grant_id_o), 32'(e.id));
                    check("wr_data", fifo_wr_data_o, e.data);
                    check("wr_ready", 32'(req_ready_o), 32'(grant_o));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_id", 32'(grant_id_o), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_wr_data", fifo_wr_data_o, 32'd0);
        cyc(1);
        rst_i = 1'b0;
        cyc(1);

        // Single requester 2, three words.
        tnum = 1;
        push_req(2, 0, 3, 1);
        exp_req(2, 0, 3);
        @(negedge clk_i);
        check("t1_dead_busy", 32'(busy_o), 32'd0);
        check("t1_dead_ready", 32'(req_ready_o), 32'd0);
        cyc(1);
        @(negedge clk_i);
        check("t1_grant", 32'(grant_o), 32'h4);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_ready", 32'(req_ready_o), 32'h4);
        cyc(3);
        @(negedge clk_i);
        check("t1_idle_busy", 32'(busy_o), 32'd0);
        check("t1_idle_grant", 32'(grant_o), 32'd0);
        check("t1_last_id", 32'(grant_id_o), 32'd2);
        check("t1_all_written", 32'(exp_q.size()), 32'd0);
        // Pointer now 3: requester 3 wins over 0.
        cyc(1);
        tnum = 11;
        push_req(0, 0, 1, 1);
        push_req(3, 0, 1, 1);
        exp_req(3, 0, 1);
        exp_req(0, 0, 1);
        wait_done(30);

        // Reset, then all four requesters stream two bursts each into an unread FIFO.
        rst_i = 1'b1;
        flush_reqs();
        preset(0);
        cyc(2);
        rst_i = 1'b0;
        tnum = 2;
        for (int r = 0; r < N; r++) begin
            push_req(r, 0, 4, 1);
            push_req(r, 4, 4, 1);
        end
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < N; r++) exp_req(r, 4 * b, 4);
        cyc(5);
        @(negedge clk_i);
        check("t2_dead_cycle", 32'(busy_o), 32'd0);
        check("t2_dead_id", 32'(grant_id_o), 32'd0);
        cyc(34);
        @(negedge clk_i);
        check("t2_final_wr", 32'(fifo_wr_en_o), 32'd1);
        check("t2_final_id", 32'(grant_id_o), 32'd3);
        cyc(1);
        @(negedge clk_i);
        check("t2_end_busy", 32'(busy_o), 32'd0);
        check("t2_usedw", 32'(fifo_wr_usedw_i), 32'd32);
        // FIFO full: requester 0 must wait.
        cyc(1);
        tnum = 3;
        push_req(0, 0, 4, 1);
        exp_req(0, 0, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("t2_withheld", 32'({busy_o, fifo_wr_en_o}), 32'd0);
            if (i < 3) cyc(1);
        end

        // usedw 29 leaves free 3: still withheld; one drained word admits the burst.
        cyc(1);
        preset(29);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("t3_free3_withheld", 32'(busy_o), 32'd0);
            cyc(1);
        end
        drain_req++;
        @(negedge clk_i);
        check("t3_drain_cyc0", 32'(busy_o), 32'd0);
        cyc(1);
        @(negedge clk_i);
        check("t3_drain_cyc1", 32'(busy_o), 32'd0);
        cyc(1);
        @(negedge clk_i);
        check("t3_grant", 32'(grant_o), 32'h1);
        cyc(3);
        @(negedge clk_i);
        check("t3_beat4_wr", 32'(fifo_wr_en_o), 32'd1);
        check("t3_beat4_full", 32'(fifo_wr_full_i), 32'd0);
        cyc(1);
        @(negedge clk_i);
        check("t3_done_busy", 32'(busy_o), 32'd0);
        check("t3_full_after", 32'(fifo_wr_full_i), 32'd1);

        // Requester 1: six words, no early last; split by BURST_MAX around others.
        cyc(1);
        preset(0);
        tnum = 4;
        push_req(1, 0, 6, 1);
        push_req(2, 0, 2, 1);
        push_req(0, 0, 1, 1);
        exp_req(1, 0, 4);
        exp_req(2, 0, 2);
        exp_req(0, 0, 1);
        exp_req(1, 4, 2);
        wait_done(80);

        // Owner 2 runs dry after two beats without last.
        tnum = 5;
        push_req(2, 0, 2, 0);
        push_req(3, 0, 2, 1);
        exp_req(2, 0, 2);
        exp_req(3, 0, 2);
        cyc(3);
        @(negedge clk_i);
        check("t5_dry_busy", 32'(busy_o), 32'd1);
        check("t5_dry_wr", 32'(fifo_wr_en_o), 32'd0);
        cyc(1);
        @(negedge clk_i);
        check("t5_end_busy", 32'(busy_o), 32'd0);
        check("t5_end_id", 32'(grant_id_o), 32'd2);
        cyc(1);
        @(negedge clk_i);
        check("t5_next_grant", 32'(grant_o), 32'h8);
        wait_done(40);

        // Move pointer to 2, then reset during beat 2 of requester 2's burst.
        tnum = 6;
        push_req(1, 0, 1, 1);
        exp_req(1, 0, 1);
        wait_done(20);
        push_req(2, 0, 4, 1);
        exp_req(2, 0, 1);
        cyc(1);
        @(negedge clk_i);
        check("t6_beat1_wr", 32'(fifo_wr_en_o), 32'd1);
        cyc(1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t6_rst_wr", 32'(fifo_wr_en_o), 32'd0);
        check("t6_rst_ready", 32'(req_ready_o), 32'd0);
        cyc(1);
        rst_i = 1'b0;
        flush_reqs();
        tnum = 7;
        for (int r = 0; r < N; r++) begin
            push_req(r, 0, 1, 1);
            exp_req(r, 0, 1);
        end
        @(negedge clk_i);
        check("t6_post_grant", 32'(grant_o), 32'd0);
        check("t6_post_busy", 32'(busy_o), 32'd0);
        cyc(1);
        @(negedge clk_i);
        check("t6_first_grant", 32'(grant_o), 32'h1);
        wait_done(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sc_fifo_wr_arbiter.md
Name: sc_fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the write port of one generic_sc_adapter_fifo among N_REQ independent writers. Each writer uses a valid/ready stream with a burst-end flag. A burst is admitted only when the FIFO has room for a full worst-case burst, so an admitted burst never stalls on full. The block sits directly in front of the FIFO write side and drives wr_en_i/wr_data_i combinationally.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 32, word width; equals FIFO WR_DATA_W
ADDR_W, 5, FIFO WR_ADDR_W; depth is 2**ADDR_W words
BURST_MAX, 4, maximum beats per grant (1..2**ADDR_W)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  N_REQ  per-requester word valid
req_data_i  in  N_REQ*DATA_W  packed words; requester k at [k*DATA_W +: DATA_W]
req_last_i  in  N_REQ  word is the final beat of the burst
req_ready_o  out  N_REQ  per-requester accept
fifo_wr_en_o  out  1  to FIFO wr_en_i
fifo_wr_data_o  out  DATA_W  to FIFO wr_data_i
fifo_wr_usedw_i  in  ADDR_W+1  from FIFO wr_usedw_o
fifo_wr_full_i  in  1  from FIFO wr_full_o
grant_o  out  N_REQ  one-hot current owner; zero when idle
grant_id_o  out  $clog2(N_REQ)  binary index of current/last owner
busy_o  out  1  state is GRANT

Behaviour:
- Reset (synchronous, rst_i high at posedge): state IDLE, grant_o=0, grant_id_o=0, rr pointer=0, beat_cnt=0. All outputs are 0 during and after reset until the first grant.
- States: IDLE and GRANT.
- IDLE:
  - free = 2**ADDR_W - fifo_wr_usedw_i.
  - If |req_valid_i and free >= BURST_MAX: select the first valid requester at or after the rr pointer, wrapping modulo N_REQ.
  - Register grant_o/grant_id_o, clear beat_cnt, go to GRANT.
  - req_ready_o=0 throughout IDLE, so there is one dead cycle per arbitration.
- GRANT:
  - req_ready_o[g] = !fifo_wr_full_i; all other readies are 0.
  - fifo_wr_en_o = req_valid_i[g] & req_ready_o[g]. fifo_wr_data_o = word of requester g, muxed combinationally (zero-cycle latency to the FIFO).
  - Each accepted beat increments beat_cnt.
  - Burst ends (go to IDLE, clear grant_o, rr pointer = g+1 mod N_REQ) on whichever comes first:
    - an accepted beat with req_last_i[g]=1;
    - the BURST_MAX-th accepted beat;
    - a cycle in GRANT with req_valid_i[g]=0. Requesters may not retract valid once asserted, so this covers an owner with nothing further to send.
- Space accounting relies on the FIFO updating wr_usedw on the same edge as the write. The IDLE cycle following a burst therefore sees the updated count. Concurrent FIFO reads only enlarge free space, which is safe.
- fifo_wr_full_i asserted in GRANT is treated as an error guard only: ready drops, no write occurs, and the grant is held.
- Width rules:
  - free is computed at ADDR_W+2 bits.
  - beat_cnt is $clog2(BURST_MAX+1) bits and never wraps.
- Handshake rule: data, valid and last are sampled only when valid & ready are both high at the posedge.
- Mid-burst reset: the burst is abandoned, no write is issued in the reset cycle, and the pointer returns to 0.

Decomposition:
- Package sc_fifo_arb_pkg: state_t enum {IDLE, GRANT}, and a localparam helper for the beat_cnt width.
- Sub-module rr_arbiter: combinational N_REQ-wide round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, binary index, any flag.
- Top level holds the FSM, pointer, beat counter and datapath mux.

Test Plan:
1. Reset, then only requester 2 valid with 3 words, last on the 3rd, FIFO empty -> IDLE 1 cycle, then GRANT; grant_o=4'b0100; 3 consecutive fifo_wr_en_o pulses with matching data; IDLE after; pointer=3.
2. All 4 requesters valid continuously, each burst of 4 with last on beat 4, FIFO never read -> grant order 0,1,2,3,0,1,2,3; every burst is 4 beats plus 1 dead cycle; FIFO reaches usedw=32 and the next grant is withheld while free=0.
3. usedw=29 with requester 0 valid -> no grant (free 3 < 4). Drain one word so usedw=28 -> grant issued the next cycle; 4 writes complete without full.
4. Requester 1 sends 6 words with no last -> first burst ends after 4 beats; requester 1 regains grant only after other valid requesters are served; remaining 2 beats arrive with last.
5. Owner drops valid after 2 beats, no last -> burst ends in that cycle; grant passes to the next valid requester; byte-level scoreboard of FIFO read data (16-bit side) matches written words in order.
6. rst_i asserted during beat 2 of a burst -> that cycle has no write; grant_o=0 and busy_o=0 the following cycle; pointer=0; the first post-reset grant goes to requester 0 when all are valid.
